// File: rtl/sdram_arbit.sv
// SDRAM command-bus arbiter: hands the bus to init, auto-refresh, write or read engines.
// Optional macro SDRAM_ARBIT_RR_EN alternates write/read when both request at once.
module sdram_arbit #(
  parameter logic [3:0] CMD_NOP = 4'b0111
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        init_done,
  input  logic [3:0]  init_cmd,
  input  logic [1:0]  init_ba,
  input  logic [11:0] init_addr,
  input  logic        ar_req,
  input  logic        ar_end,
  input  logic [3:0]  ar_cmd,
  input  logic [1:0]  ar_ba,
  input  logic [11:0] ar_addr,
  input  logic        wr_req,
  input  logic        wr_end,
  input  logic        wr_sdram_en,
  input  logic [3:0]  wr_cmd,
  input  logic [1:0]  wr_ba,
  input  logic [11:0] wr_addr,
  input  logic [15:0] wr_data,
  input  logic        rd_req,
  input  logic        rd_end,
  input  logic [3:0]  rd_cmd,
  input  logic [1:0]  rd_ba,
  input  logic [11:0] rd_addr,
  output logic        ar_en,
  output logic        wr_en,
  output logic        rd_en,
  output logic        sdram_cke,
  output logic [3:0]  sdram_cmd,
  output logic [1:0]  sdram_ba,
  output logic [11:0] sdram_addr,
  output logic [15:0] sdram_dq_out,
  output logic        sdram_dq_oe
);

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_ARBIT = 3'd1,
    S_AREF  = 3'd2,
    S_WRITE = 3'd3,
    S_READ  = 3'd4
  } state_t;

  state_t state_q, state_d;
  logic   in_arbit;
  logic   read_first;

`ifdef SDRAM_ARBIT_RR_EN
  typedef enum logic {LG_WRITE = 1'b0, LG_READ = 1'b1} last_grant_t;
  last_grant_t last_grant_q, last_grant_d;

  // On a write/read tie, the engine that did not win last time goes first.
  assign read_first = (last_grant_q == LG_WRITE);

  always_comb begin
    last_grant_d = last_grant_q;
    if (wr_en) last_grant_d = LG_WRITE;
    else if (rd_en) last_grant_d = LG_READ;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) last_grant_q <= LG_READ;
    else         last_grant_q <= last_grant_d;
  end
`else
  assign read_first = 1'b0;
`endif

  assign in_arbit = (state_q == S_ARBIT);
  assign ar_en    = in_arbit && ar_req;
  assign wr_en    = in_arbit && !ar_req && wr_req && !(rd_req && read_first);
  assign rd_en    = in_arbit && !ar_req && rd_req && (!wr_req || read_first);

  // Each busy state returns to ARBIT on its own end, so back-to-back
  // transactions always pass through one ARBIT cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:  if (init_done) state_d = S_ARBIT;
      S_ARBIT: begin
        if (ar_en)      state_d = S_AREF;
        else if (wr_en) state_d = S_WRITE;
        else if (rd_en) state_d = S_READ;
      end
      S_AREF:  if (ar_end) state_d = S_ARBIT;
      S_WRITE: if (wr_end) state_d = S_ARBIT;
      S_READ:  if (rd_end) state_d = S_ARBIT;
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state_q <= S_INIT;
    else         state_q <= state_d;
  end

  always_comb begin
    sdram_cmd   = CMD_NOP;
    sdram_ba    = 2'b11;
    sdram_addr  = 12'hFFF;
    sdram_dq_oe = 1'b0;
    case (state_q)
      S_INIT: begin
        sdram_cmd  = init_cmd;
        sdram_ba   = init_ba;
        sdram_addr = init_addr;
      end
      S_AREF: begin
        sdram_cmd  = ar_cmd;
        sdram_ba   = ar_ba;
        sdram_addr = ar_addr;
      end
      S_WRITE: begin
        sdram_cmd   = wr_cmd;
        sdram_ba    = wr_ba;
        sdram_addr  = wr_addr;
        sdram_dq_oe = wr_sdram_en;
      end
      S_READ: begin
        sdram_cmd  = rd_cmd;
        sdram_ba   = rd_ba;
        sdram_addr = rd_addr;
      end
      default: ;
    endcase
  end

  assign sdram_cke    = 1'b1;
  assign sdram_dq_out = wr_data;

endmodule

// File: tb/tb_sdram_arbit.sv
// Bench for sdram_arbit: directed scenarios then random traffic against an owner-tracking model.
module tb_sdram_arbit;

  localparam int M_INIT = 0, M_ARBIT = 1, M_AREF = 2, M_WRITE = 3, M_READ = 4;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        init_done = 1'b0;
  logic [3:0]  init_cmd = 4'hE;
  logic [1:0]  init_ba = 2'd0;
  logic [11:0] init_addr = 12'd0;
  logic        ar_req = 1'b0, ar_end = 1'b0;
  logic [3:0]  ar_cmd = 4'h2;
  logic [1:0]  ar_ba = 2'd0;
  logic [11:0] ar_addr = 12'd0;
  logic        wr_req = 1'b0, wr_end = 1'b0, wr_sdram_en = 1'b0;
  logic [3:0]  wr_cmd = 4'h4;
  logic [1:0]  wr_ba = 2'd0;
  logic [11:0] wr_addr = 12'd0;
  logic [15:0] wr_data = 16'd0;
  logic        rd_req = 1'b0, rd_end = 1'b0;
  logic [3:0]  rd_cmd = 4'h5;
  logic [1:0]  rd_ba = 2'd0;
  logic [11:0] rd_addr = 12'd0;
  logic        ar_en, wr_en, rd_en, sdram_cke, sdram_dq_oe;
  logic [3:0]  sdram_cmd;
  logic [1:0]  sdram_ba;
  logic [11:0] sdram_addr;
  logic [15:0] sdram_dq_out;

  int errors = 0;
  int checks = 0;

  // Model: who owns the bus, and which of write/read was last served.
  int m_owner;
  int m_last_wr;

  logic        obs_ar, obs_wr, obs_rd, obs_oe;
  logic [3:0]  obs_cmd;
  logic [1:0]  obs_ba;
  logic [11:0] obs_addr;
  logic        seq_wr [3];
  logic        seq_rd [3];

  sdram_arbit dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .init_done(init_done), .init_cmd(init_cmd), .init_ba(init_ba), .init_addr(init_addr),
    .ar_req(ar_req), .ar_end(ar_end), .ar_cmd(ar_cmd), .ar_ba(ar_ba), .ar_addr(ar_addr),
    .wr_req(wr_req), .wr_end(wr_end), .wr_sdram_en(wr_sdram_en), .wr_cmd(wr_cmd),
    .wr_ba(wr_ba), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_req(rd_req), .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_ba(rd_ba), .rd_addr(rd_addr),
    .ar_en(ar_en), .wr_en(wr_en), .rd_en(rd_en),
    .sdram_cke(sdram_cke), .sdram_cmd(sdram_cmd), .sdram_ba(sdram_ba), .sdram_addr(sdram_addr),
    .sdram_dq_out(sdram_dq_out), .sdram_dq_oe(sdram_dq_oe)
  );

  always #5 sys_clk = ~sys_clk;

  // Who the arbiter hands the bus to, given the current requests.
  function automatic int winner();
    if (ar_req) return M_AREF;
    if (wr_req && rd_req) begin
`ifdef SDRAM_ARBIT_RR_EN
      return (m_last_wr == 1) ? M_READ : M_WRITE;
`else
      return M_WRITE;
`endif
    end
    if (wr_req) return M_WRITE;
    if (rd_req) return M_READ;
    return M_ARBIT;
  endfunction

  task automatic check_outputs();
    int w;
    logic [3:0] e_cmd;
    logic [1:0] e_ba;
    logic [11:0] e_addr;
    w = (m_owner == M_ARBIT && !sys_rst) ? winner() : M_ARBIT;
    case (m_owner)
      M_INIT:  begin e_cmd = init_cmd; e_ba = init_ba; e_addr = init_addr; end
      M_AREF:  begin e_cmd = ar_cmd;   e_ba = ar_ba;   e_addr = ar_addr;   end
      M_WRITE: begin e_cmd = wr_cmd;   e_ba = wr_ba;   e_addr = wr_addr;   end
      M_READ:  begin e_cmd = rd_cmd;   e_ba = rd_ba;   e_addr = rd_addr;   end
      default: begin e_cmd = 4'b0111;  e_ba = 2'b11;   e_addr = 12'hFFF;   end
    endcase
    checks++;
    assert (ar_en === (w == M_AREF)) else begin
      errors++; $error("FAIL ar_en got=%0b exp=%0b t=%0t", ar_en, (w == M_AREF), $time);
    end
    checks++;
    assert (wr_en === (w == M_WRITE)) else begin
      errors++; $error("FAIL wr_en got=%0b exp=%0b t=%0t", wr_en, (w == M_WRITE), $time);
    end
    checks++;
    assert (rd_en === (w == M_READ)) else begin
      errors++; $error("FAIL rd_en got=%0b exp=%0b t=%0t", rd_en, (w == M_READ), $time);
    end
    checks++;
    assert ({sdram_cmd, sdram_ba, sdram_addr} === {e_cmd, e_ba, e_addr}) else begin
      errors++; $error("FAIL bus got=%h/%h/%h exp=%h/%h/%h t=%0t",
                       sdram_cmd, sdram_ba, sdram_addr, e_cmd, e_ba, e_addr, $time);
    end
    checks++;
    assert (sdram_dq_oe === (m_owner == M_WRITE && wr_sdram_en)) else begin
      errors++; $error("FAIL dq_oe got=%0b exp=%0b t=%0t", sdram_dq_oe,
                       (m_owner == M_WRITE && wr_sdram_en), $time);
    end
    checks++;
    assert ({sdram_cke, sdram_dq_out} === {1'b1, wr_data}) else begin
      errors++; $error("FAIL cke_dq got=%0b/%h exp=1/%h t=%0t", sdram_cke, sdram_dq_out, wr_data, $time);
    end
    obs_ar = ar_en; obs_wr = wr_en; obs_rd = rd_en; obs_oe = sdram_dq_oe;
    obs_cmd = sdram_cmd; obs_ba = sdram_ba; obs_addr = sdram_addr;
  endtask

  task automatic model_advance();
    int w;
    if (sys_rst) begin
      m_owner = M_INIT;
      m_last_wr = 0;
      return;
    end
    case (m_owner)
      M_INIT:  if (init_done) m_owner = M_ARBIT;
      M_ARBIT: begin
        w = winner();
        if (w == M_WRITE) m_last_wr = 1;
        if (w == M_READ)  m_last_wr = 0;
        m_owner = w;
      end
      M_AREF:  if (ar_end) m_owner = M_ARBIT;
      M_WRITE: if (wr_end) m_owner = M_ARBIT;
      M_READ:  if (rd_end) m_owner = M_ARBIT;
      default: m_owner = M_INIT;
    endcase
  endtask

  task automatic step();
    @(negedge sys_clk);
    check_outputs();
    @(posedge sys_clk);
    model_advance();
    #1;
    init_ba = 2'($urandom); init_addr = 12'($urandom);
    ar_ba = 2'($urandom);   ar_addr = 12'($urandom);
    wr_ba = 2'($urandom);   wr_addr = 12'($urandom);
    rd_ba = 2'($urandom);   rd_addr = 12'($urandom);
  endtask

  task automatic dcheck(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++; $error("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  initial begin
    m_owner = M_INIT;
    m_last_wr = 0;
    sys_rst = 1'b1;
    ar_req = 1'b1;
    repeat (5) step();
    sys_rst = 1'b0;
    repeat (3) step();
    dcheck("hold_init_ar_en", 16'(obs_ar), 16'd0);
    dcheck("hold_init_cmd", 16'(obs_cmd), 16'(init_cmd));

    init_done = 1'b1;
    step();
    wr_req = 1'b1; rd_req = 1'b1;
    step();
    dcheck("first_ar_grant", 16'(obs_ar), 16'd1);
    ar_cmd = 4'b0010;
    step();
    dcheck("aref_cmd_0010", 16'(obs_cmd), 16'h2);
    ar_cmd = 4'b0001;
    step();
    dcheck("aref_cmd_0001", 16'(obs_cmd), 16'h1);
    ar_req = 1'b0; ar_end = 1'b1;
    step();
    ar_end = 1'b0;
    step();
    dcheck("wr_after_aref", {13'd0, obs_ar, obs_wr, obs_rd}, 16'b010);

    wr_sdram_en = 1'b1; wr_data = 16'hA5C3;
    step();
    dcheck("write_dq_oe", 16'(obs_oe), 16'd1);
    dcheck("write_dq_out", sdram_dq_out, 16'hA5C3);

    rd_end = 1'b1;
    step();
    rd_end = 1'b0;
    step();
    dcheck("ignore_rd_end", 16'(obs_cmd), 16'(wr_cmd));
    wr_req = 1'b0; wr_end = 1'b1;
    step();
    wr_end = 1'b0;
    step();
    dcheck("rd_grant", 16'(obs_rd), 16'd1);
    step();
    dcheck("read_no_oe", 16'(obs_oe), 16'd0);
    rd_req = 1'b0; rd_end = 1'b1;
    step();
    rd_end = 1'b0;
    step();
    dcheck("idle_bus", {obs_cmd, obs_ba, obs_addr[9:0]}, {4'b0111, 2'b11, 10'h3FF});
    dcheck("idle_addr", 16'(obs_addr), 16'hFFF);

    wr_req = 1'b1; rd_req = 1'b1;
    step();
    step();
    sys_rst = 1'b1;
    #1;
    dcheck("rst_mid_write", {13'd0, wr_en, sdram_dq_oe, 1'b0}, 16'd0);
    dcheck("rst_cmd", 16'(sdram_cmd), 16'(init_cmd));
    m_owner = M_INIT;
    m_last_wr = 0;
    init_done = 1'b0;
    repeat (2) step();
    sys_rst = 1'b0;
    repeat (4) step();
    dcheck("no_grant_after_rst", {13'd0, obs_ar, obs_wr, obs_rd}, 16'd0);
    init_done = 1'b1;
    step();
    for (int t = 0; t < 3; t++) begin
      step();
      seq_wr[t] = obs_wr; seq_rd[t] = obs_rd;
      step();
      wr_end = 1'b1; rd_end = 1'b1;
      step();
      wr_end = 1'b0; rd_end = 1'b0;
    end
`ifdef SDRAM_ARBIT_RR_EN
    dcheck("tie_seq", {10'd0, seq_wr[0], seq_rd[0], seq_wr[1], seq_rd[1], seq_wr[2], seq_rd[2]},
           16'b10_01_10);
`else
    dcheck("tie_seq", {10'd0, seq_wr[0], seq_rd[0], seq_wr[1], seq_rd[1], seq_wr[2], seq_rd[2]},
           16'b10_10_10);
`endif

    for (int i = 0; i < 500; i++) begin
      sys_rst     = ($urandom_range(0, 59) == 0);
      init_done   = ($urandom_range(0, 7) != 0);
      ar_req      = ($urandom_range(0, 5) == 0);
      wr_req      = $urandom_range(0, 1) == 1;
      rd_req      = $urandom_range(0, 1) == 1;
      ar_end      = ($urandom_range(0, 3) == 0);
      wr_end      = ($urandom_range(0, 3) == 0);
      rd_end      = ($urandom_range(0, 3) == 0);
      wr_sdram_en = $urandom_range(0, 1) == 1;
      wr_data     = 16'($urandom);
      init_cmd    = 4'($urandom);
      ar_cmd      = 4'($urandom);
      wr_cmd      = 4'($urandom);
      rd_cmd      = 4'($urandom);
      if (sys_rst) begin
        m_owner = M_INIT;
        m_last_wr = 0;
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sdram_arbit.md
SDRAM_ARBIT -- requirements
Module: sdram_arbit

Interface
REQ-001 SHALL have parameter CMD_NOP, default 4'b0111, command driven while no sub-block owns the bus.
REQ-002 SHALL have port sys_clk  in  1  system clock (100 MHz); all state changes on its rising edge.
REQ-003 SHALL have port sys_rst  in  1  reset, asynchronous and active-high.
REQ-004 SHALL have ports init_done in 1, init_cmd in 4, init_ba in 2, init_addr in 12: init-sequencer status and bus.
REQ-005 SHALL have ports ar_req in 1, ar_end in 1, ar_cmd in 4, ar_ba in 2, ar_addr in 12: auto-refresh request, end and bus.
REQ-006 SHALL have ports wr_req, wr_end, wr_sdram_en in 1, wr_cmd in 4, wr_ba in 2, wr_addr in 12, wr_data in 16: write engine.
REQ-007 SHALL have ports rd_req, rd_end in 1, rd_cmd in 4, rd_ba in 2, rd_addr in 12: read engine.
REQ-008 SHALL have ports ar_en, wr_en, rd_en  out  1  grant to each engine.
REQ-009 SHALL have ports sdram_cke out 1, sdram_cmd out 4 ({cs_n,ras_n,cas_n,we_n}), sdram_ba out 2, sdram_addr out 12, sdram_dq_out out 16, sdram_dq_oe out 1.

Function
REQ-010 SHALL implement states INIT, ARBIT, AREF, WRITE, READ in a registered state variable.
REQ-011 INIT -> ARBIT when init_done=1; otherwise stays in INIT.
REQ-012 In ARBIT, priority: ar_req -> AREF; else wr_req -> WRITE; else rd_req -> READ; else stay in ARBIT.
REQ-013 ar_en SHALL be combinational: 1 only while state=ARBIT and ar_req=1; wr_en and rd_en likewise, each qualified by the priority of REQ-012, so at most one grant is high.
REQ-014 Each grant SHALL be high for exactly one cycle per transaction, namely the cycle on whose closing edge the state leaves ARBIT.
REQ-015 AREF -> ARBIT on ar_end=1; WRITE -> ARBIT on wr_end=1; READ -> ARBIT on rd_end=1; end signals of non-owning engines are ignored.
REQ-016 At least one ARBIT cycle SHALL separate consecutive transactions, even if a new request is high in the same cycle as the end signal.
REQ-017 sdram_cmd/ba/addr SHALL be a combinational mux of the owner's bus (INIT: init_*, AREF: ar_*, WRITE: wr_*, READ: rd_*); in ARBIT: CMD_NOP, 2'b11, 12'hFFF.
REQ-018 sdram_cke SHALL be constant 1.
REQ-019 sdram_dq_out SHALL equal wr_data.
REQ-020 sdram_dq_oe SHALL equal wr_sdram_en when state=WRITE, and 0 otherwise.
REQ-021 Requests arriving in INIT SHALL be held off, not dropped; they are served once ARBIT is reached and the request is still high.
REQ-022 An unreachable state encoding SHALL recover to INIT on the next edge.

Reset
REQ-023 sys_rst=1 SHALL force state to INIT immediately, even mid-transaction.
REQ-024 During reset: ar_en/wr_en/rd_en=0, sdram_dq_oe=0, sdram_cke=1, sdram_cmd/ba/addr follow init_*.
REQ-025 After reset release the block SHALL re-wait for init_done; no transaction resumes.

Configuration
REQ-026 Macro SDRAM_ARBIT_RR_EN SHALL select the write/read tie-break.
REQ-027 With the macro defined: a last_grant register (reset = READ) records the last of WRITE/READ granted; when wr_req and rd_req are both high with ar_req=0, the engine not last granted wins; refresh still has top priority.
REQ-028 With the macro undefined: fixed priority per REQ-012, and no last_grant register exists.

Verification
REQ-029 Reset 5 cycles, init_done=0 with ar_req=1 -> state stays INIT, ar_en=0, sdram_cmd=init_cmd; then init_done=1 -> ARBIT next edge, ar_en=1 one cycle.
REQ-030 In ARBIT, ar_req=wr_req=rd_req=1 -> ar_en pulses, AREF entered, sdram_cmd tracks ar_cmd (0010 then 0001); ar_end -> ARBIT 1 cycle -> wr_en pulses.
REQ-031 WRITE with wr_sdram_en=1, wr_data=16'hA5C3 -> sdram_dq_oe=1, sdram_dq_out=16'hA5C3; in READ with wr_sdram_en=1 -> sdram_dq_oe=0.
REQ-032 wr_req and rd_req held high, three transactions -> without macro: WRITE,WRITE,WRITE; with SDRAM_ARBIT_RR_EN: WRITE,READ,WRITE.
REQ-033 sys_rst asserted mid-WRITE -> wr_en=0, sdram_dq_oe=0 immediately, state INIT; after release, no grant until init_done=1.
REQ-034 rd_end pulsed while in WRITE -> state stays WRITE until wr_end; in ARBIT with no requests -> sdram_cmd=4'b0111, sdram_ba=2'b11, sdram_addr=12'hFFF.
